// File: rtl/mem_issue_queue.sv
// Load/store request queue between the CPU memory stage and memops: buffers
// requests and issues them one strobe at a time. Optional MEMQ_SCOREBOARD_EN adds a pending-load register mask.
module mem_issue_queue #(
  parameter int LGDEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_oreg,
  output logic        o_stall,
  output logic        o_empty,
  output logic [LGDEPTH:0] o_count,
  output logic        o_mem_stb,
  output logic [2:0]  o_mem_op,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic [4:0]  o_mem_oreg,
  input  logic        i_mem_busy,
  input  logic        i_mem_valid,
  input  logic        i_mem_err,
  output logic        o_err,
  output logic [31:0] o_pend_mask
);
  localparam int DEPTH = 2**LGDEPTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t              r_state;
  logic [2:0]          r_q_op   [DEPTH];
  logic [31:0]         r_q_addr [DEPTH];
  logic [31:0]         r_q_data [DEPTH];
  logic [4:0]          r_q_oreg [DEPTH];
  logic [LGDEPTH-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LGDEPTH:0]    r_count;
  logic                r_mem_stb, r_err;
  logic [2:0]          r_mem_op;
  logic [31:0]         r_mem_addr, r_mem_data;
  logic [4:0]          r_mem_oreg;
  logic                w_full, w_push, w_pop, w_flush, w_nonempty;

  // Handshake: a request transfers on any cycle with i_stb && !o_stall. There is
  // no full bypass, and an error cycle refuses pushes so the flush cannot race one.
  assign w_full     = (r_count == (LGDEPTH+1)'(DEPTH));
  assign o_stall    = w_full || i_mem_err;
  assign w_push     = i_stb && !o_stall;
  assign w_nonempty = (r_count != '0);
  assign w_flush    = (r_state == S_WAIT) && i_mem_err;
  assign w_pop      = w_nonempty && !i_mem_busy &&
                      ((r_state == S_IDLE) || ((r_state == S_WAIT) && !i_mem_err));

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_op[r_wr_ptr]   <= i_op;
      r_q_addr[r_wr_ptr] <= i_addr;
      r_q_data[r_wr_ptr] <= i_data;
      r_q_oreg[r_wr_ptr] <= i_oreg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mem_stb  <= 1'b0;
      r_err      <= 1'b0;
      r_mem_op   <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_oreg <= '0;
    end else begin
      r_mem_stb <= 1'b0;
      r_err     <= w_flush;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + LGDEPTH'(1);
      if (w_flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + LGDEPTH'(1);
        if (w_push && !w_pop)
          r_count <= r_count + (LGDEPTH+1)'(1);
        else if (w_pop && !w_push)
          r_count <= r_count - (LGDEPTH+1)'(1);
      end
      if (w_pop) begin
        r_mem_stb  <= 1'b1;
        r_mem_op   <= r_q_op[r_rd_ptr];
        r_mem_addr <= r_q_addr[r_rd_ptr];
        r_mem_data <= r_q_data[r_rd_ptr];
        r_mem_oreg <= r_q_oreg[r_rd_ptr];
      end
      // memops raises busy in the first WAIT cycle, so WAIT cannot leave early.
      case (r_state)
        S_IDLE:  if (w_pop) r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_mem_err)
            r_state <= S_IDLE;
          else if (!i_mem_busy)
            r_state <= w_pop ? S_ISSUE : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_empty    = (r_count == '0) && (r_state == S_IDLE);
  assign o_count    = r_count;
  assign o_mem_stb  = r_mem_stb;
  assign o_mem_op   = r_mem_op;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_mem_oreg = r_mem_oreg;
  assign o_err      = r_err;

`ifdef MEMQ_SCOREBOARD_EN
  logic        r_inflight_ld;
  logic [31:0] w_mask;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush)
      r_inflight_ld <= 1'b0;
    else if (w_pop)
      r_inflight_ld <= !r_q_op[r_rd_ptr][0];
    else if ((r_state == S_WAIT) && (i_mem_valid || i_mem_err))
      r_inflight_ld <= 1'b0;
  end

  // Walk the live window from the read pointer; entries past r_count are stale.
  always_comb begin
    logic [LGDEPTH-1:0] idx;
    w_mask = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + LGDEPTH'(i);
      if (((LGDEPTH+1)'(i) < r_count) && !r_q_op[idx][0])
        w_mask[r_q_oreg[idx]] = 1'b1;
    end
    if (r_inflight_ld)
      w_mask[r_mem_oreg] = 1'b1;
  end

  assign o_pend_mask = w_mask;
`else
  logic w_unused_valid;
  assign w_unused_valid = i_mem_valid;
  assign o_pend_mask    = 32'h0;
`endif
endmodule
